// File: rtl/trip_status_generator.sv
// Trip/thermal status producer: counts a trip down to its destination while burning fuel,
// and raises a hysteresis-filtered CPU overheat flag independently of the trip FSM.
module trip_status_generator #(
    parameter int unsigned DIST_W   = 16,
    parameter int unsigned FUEL_W   = 8,
    parameter int unsigned TEMP_W   = 8,
    parameter int unsigned BURN_DIV = 4,
    parameter int unsigned TEMP_HI  = 100,
    parameter int unsigned TEMP_LO  = 90
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DIST_W-1:0] dest_dist,
    input  logic [FUEL_W-1:0] fuel_init,
    input  logic              keep_driving,
    input  logic              shut_off_computer,
    input  logic [TEMP_W-1:0] temp,
    output logic              arrived,
    output logic              gas_tank_empty,
    output logic              cpu_overheated,
    output logic [DIST_W-1:0] odometer,
    output logic [FUEL_W-1:0] fuel_level,
    output logic [1:0]        trip_state
);

    localparam int unsigned BURN_W = (BURN_DIV > 1) ? $clog2(BURN_DIV) : 1;
    localparam logic [BURN_W-1:0] BURN_LAST = BURN_W'(BURN_DIV - 1);
    localparam logic [TEMP_W-1:0] HI_THR    = TEMP_W'(TEMP_HI);
    localparam logic [TEMP_W-1:0] LO_THR    = TEMP_W'(TEMP_LO);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRIVING  = 2'd1,
        S_ARRIVED  = 2'd2,
        S_STRANDED = 2'd3
    } trip_state_t;

    trip_state_t       r_state;
    trip_state_t       w_state_nxt;
    logic [DIST_W-1:0] r_remaining;
    logic [DIST_W-1:0] w_remaining_nxt;
    logic [DIST_W-1:0] r_odometer;
    logic [DIST_W-1:0] w_odometer_nxt;
    logic [FUEL_W-1:0] r_fuel;
    logic [FUEL_W-1:0] w_fuel_nxt;
    logic [BURN_W-1:0] r_burn_cnt;
    logic [BURN_W-1:0] w_burn_nxt;
    logic              r_arrived;
    logic              r_empty;
    logic              r_overheated;
    logic              w_advance;

    assign w_advance = (r_state == S_DRIVING) && keep_driving && !shut_off_computer;

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_odometer_nxt  = r_odometer;
        w_fuel_nxt      = r_fuel;
        w_burn_nxt      = r_burn_cnt;
        if (load) begin
            w_remaining_nxt = dest_dist;
            w_fuel_nxt      = fuel_init;
            w_odometer_nxt  = '0;
            w_burn_nxt      = '0;
            if (dest_dist == '0)
                w_state_nxt = S_ARRIVED;
            else if (fuel_init == '0)
                w_state_nxt = S_STRANDED;
            else
                w_state_nxt = S_DRIVING;
        end else if (w_advance) begin
            if (r_remaining != '0)
                w_remaining_nxt = r_remaining - 1'b1;
            if (r_odometer != '1)
                w_odometer_nxt = r_odometer + 1'b1;
            if (r_burn_cnt == BURN_LAST) begin
                w_burn_nxt = '0;
                if (r_fuel != '0)
                    w_fuel_nxt = r_fuel - 1'b1;
            end else begin
                w_burn_nxt = r_burn_cnt + 1'b1;
            end
            // Arrival outranks running dry when both happen on the same step
            if (w_remaining_nxt == '0)
                w_state_nxt = S_ARRIVED;
            else if (w_fuel_nxt == '0)
                w_state_nxt = S_STRANDED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_odometer  <= '0;
            r_fuel      <= '0;
            r_burn_cnt  <= '0;
            r_arrived   <= 1'b0;
            r_empty     <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_odometer  <= w_odometer_nxt;
            r_fuel      <= w_fuel_nxt;
            r_burn_cnt  <= w_burn_nxt;
            r_arrived   <= (w_state_nxt == S_ARRIVED);
            r_empty     <= (w_fuel_nxt == '0);
        end
    end

    // Between the thresholds the flag keeps its previous value
    always_ff @(posedge clk) begin
        if (reset)
            r_overheated <= 1'b0;
        else if (temp >= HI_THR)
            r_overheated <= 1'b1;
        else if (temp <= LO_THR)
            r_overheated <= 1'b0;
    end

    assign arrived        = r_arrived;
    assign gas_tank_empty = r_empty;
    assign cpu_overheated = r_overheated;
    assign odometer       = r_odometer;
    assign fuel_level     = r_fuel;
    assign trip_state     = r_state;

endmodule
